// File: rtl/gerenciador_jogo_param_if.sv
// Bundle between the switch/button front end (master) and the battleship game controller (slave).
// Widths derive from the map geometry and life count.
`timescale 1ns/1ps
interface gerenciador_jogo_param_if #(
   parameter int ROWS  = 7,
   parameter int COLS  = 5,
   parameter int LIVES = 3
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int VW = $clog2(LIVES + 1);
   localparam int N  = ROWS * COLS;

   logic [1:0]       modo;
   logic             confirmar;
   logic [N-1:0]     mapa_in;
   logic [RW-1:0]    coord_linha;
   logic [CW-1:0]    coord_coluna;
   logic [N-1:0]     mapa;
   logic [N-1:0]     atacadas;
   logic [N-1:0]     acertos;
   logic [VW-1:0]    vida;
   logic [RW+CW:0]   navios_restantes;
   logic [2:0]       estado;
   logic [2:0]       resultado;
   logic             resultado_valido;

   modport master (
      output modo, confirmar, mapa_in, coord_linha, coord_coluna,
      input  mapa, atacadas, acertos, vida, navios_restantes, estado, resultado, resultado_valido
   );

   modport slave (
      input  modo, confirmar, mapa_in, coord_linha, coord_coluna,
      output mapa, atacadas, acertos, vida, navios_restantes, estado, resultado, resultado_valido
   );
endinterface

// File: rtl/gerenciador_jogo_param.sv
// Battleship game controller: latches the ship map, resolves attacks, tracks lives and ships,
// and declares victory or defeat. Every output is registered.
`timescale 1ns/1ps
module gerenciador_jogo_param #(
   parameter int ROWS  = 7,
   parameter int COLS  = 5,
   parameter int LIVES = 3
) (
   input logic                     clock_in,
   input logic                     reset_n,
   gerenciador_jogo_param_if.slave bus
);
   localparam int          RW = $clog2(ROWS);
   localparam int          CW = $clog2(COLS);
   localparam int          VW = $clog2(LIVES + 1);
   localparam int unsigned N  = ROWS * COLS;
   localparam int          NW = RW + CW + 1;

   localparam logic [VW-1:0] VIDA_INI = VW'(LIVES);
   localparam logic [NW-1:0] COLS_W   = NW'(COLS);

   typedef enum logic [2:0] {
      DESLIGADO  = 3'd0,
      PREPARACAO = 3'd1,
      ATAQUE     = 3'd2,
      VITORIA    = 3'd3,
      DERROTA    = 3'd4
   } estado_t;

   typedef enum logic [2:0] {
      RES_NENHUM     = 3'd0,
      RES_ACERTO     = 3'd1,
      RES_ERRO       = 3'd2,
      RES_REPETIDO   = 3'd3,
      RES_INVALIDO   = 3'd4,
      RES_MAPA_OK    = 3'd5,
      RES_MAPA_VAZIO = 3'd6
   } resultado_t;

   typedef enum logic [1:0] {
      MODO_DESL = 2'b00,
      MODO_PREP = 2'b01,
      MODO_ATAQ = 2'b10,
      MODO_RES  = 2'b11
   } modo_t;

   estado_t       estado_q, estado_d;
   resultado_t    resultado_q, resultado_d;
   logic [N-1:0]  mapa_q, mapa_d;
   logic [N-1:0]  atacadas_q, atacadas_d;
   logic [N-1:0]  acertos_q, acertos_d;
   logic [VW-1:0] vida_q, vida_d;
   logic [NW-1:0] navios_q, navios_d;
   logic [NW-1:0] total_q, total_d;
   logic          carregado_q, carregado_d;
   logic          valido_q, valido_d;

   logic          coord_ok;
   logic [NW-1:0] idx;
   logic [N-1:0]  sel;
   logic          alvo_navio;
   logic          alvo_repetido;
   logic [NW-1:0] contagem;
   logic          troca_modo;
   logic          entra_ataque;
   logic          ataque_novo;
   logic          ultimo_acerto;
   logic          ultimo_erro;

   // Any mode-driven transition swallows a coincident confirmar.
   always_comb begin : decode
      coord_ok      = (int'(bus.coord_linha) < ROWS) && (int'(bus.coord_coluna) < COLS);
      idx           = NW'(bus.coord_linha) * COLS_W + NW'(bus.coord_coluna);
      sel           = coord_ok ? (N'(1) << idx) : '0;
      alvo_navio    = |(mapa_q & sel);
      alvo_repetido = |(atacadas_q & sel);
      contagem      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         contagem = contagem + NW'(bus.mapa_in[i]);
      end
      entra_ataque  = (estado_q == PREPARACAO) && (bus.modo == MODO_ATAQ) && carregado_q;
      troca_modo    = (bus.modo == MODO_DESL)
                   || ((estado_q == DESLIGADO) && (bus.modo == MODO_PREP))
                   || entra_ataque
                   || ((estado_q == ATAQUE) && (bus.modo == MODO_PREP));
      ataque_novo   = (estado_q == ATAQUE) && bus.confirmar && !troca_modo
                   && coord_ok && !alvo_repetido;
      ultimo_acerto = ataque_novo && alvo_navio && (navios_q == NW'(1));
      ultimo_erro   = ataque_novo && !alvo_navio && (vida_q == VW'(1));
   end

   always_ff @(posedge clock_in or negedge reset_n) begin : estado_reg
      if (!reset_n) estado_q <= DESLIGADO;
      else          estado_q <= estado_d;
   end

   always_comb begin : proximo_estado
      estado_d = estado_q;
      if (bus.modo == MODO_DESL) begin
         estado_d = DESLIGADO;
      end else begin
         case (estado_q)
            DESLIGADO:  if (bus.modo == MODO_PREP) estado_d = PREPARACAO;
            PREPARACAO: if (entra_ataque) estado_d = ATAQUE;
            ATAQUE: begin
               if (bus.modo == MODO_PREP) estado_d = PREPARACAO;
               else if (ultimo_acerto)    estado_d = VITORIA;
               else if (ultimo_erro)      estado_d = DERROTA;
            end
            default: estado_d = estado_q;
         endcase
      end
   end

   always_comb begin : proximo_dados
      mapa_d      = mapa_q;
      atacadas_d  = atacadas_q;
      acertos_d   = acertos_q;
      vida_d      = vida_q;
      navios_d    = navios_q;
      total_d     = total_q;
      carregado_d = carregado_q;
      resultado_d = resultado_q;
      valido_d    = 1'b0;
      if (bus.modo == MODO_DESL) begin
         mapa_d      = '0;
         atacadas_d  = '0;
         acertos_d   = '0;
         vida_d      = VIDA_INI;
         navios_d    = '0;
         total_d     = '0;
         carregado_d = 1'b0;
         resultado_d = RES_NENHUM;
      end else if (entra_ataque) begin
         // A fresh attack round restores the full ship count of the latched map.
         atacadas_d = '0;
         acertos_d  = '0;
         vida_d     = VIDA_INI;
         navios_d   = total_q;
      end else if (bus.confirmar && !troca_modo) begin
         if (estado_q == PREPARACAO) begin
            valido_d = 1'b1;
            if (contagem != '0) begin
               mapa_d      = bus.mapa_in;
               navios_d    = contagem;
               total_d     = contagem;
               carregado_d = 1'b1;
               resultado_d = RES_MAPA_OK;
            end else begin
               resultado_d = RES_MAPA_VAZIO;
            end
         end else if (estado_q == ATAQUE) begin
            valido_d = 1'b1;
            if (!coord_ok) begin
               resultado_d = RES_INVALIDO;
            end else if (alvo_repetido) begin
               resultado_d = RES_REPETIDO;
            end else if (alvo_navio) begin
               atacadas_d  = atacadas_q | sel;
               acertos_d   = acertos_q | sel;
               if (navios_q != '0) navios_d = navios_q - NW'(1);
               resultado_d = RES_ACERTO;
            end else begin
               atacadas_d  = atacadas_q | sel;
               if (vida_q != '0) vida_d = vida_q - VW'(1);
               resultado_d = RES_ERRO;
            end
         end
      end
   end

   always_ff @(posedge clock_in or negedge reset_n) begin : dados_reg
      if (!reset_n) begin
         mapa_q      <= '0;
         atacadas_q  <= '0;
         acertos_q   <= '0;
         vida_q      <= VIDA_INI;
         navios_q    <= '0;
         total_q     <= '0;
         carregado_q <= 1'b0;
         resultado_q <= RES_NENHUM;
         valido_q    <= 1'b0;
      end else begin
         mapa_q      <= mapa_d;
         atacadas_q  <= atacadas_d;
         acertos_q   <= acertos_d;
         vida_q      <= vida_d;
         navios_q    <= navios_d;
         total_q     <= total_d;
         carregado_q <= carregado_d;
         resultado_q <= resultado_d;
         valido_q    <= valido_d;
      end
   end

   assign bus.mapa             = mapa_q;
   assign bus.atacadas         = atacadas_q;
   assign bus.acertos          = acertos_q;
   assign bus.vida             = vida_q;
   assign bus.navios_restantes = navios_q;
   assign bus.estado           = estado_q;
   assign bus.resultado        = resultado_q;
   assign bus.resultado_valido = valido_q;
endmodule
